// File: rtl/periph_cmd_pkg.sv
// rtl/periph_cmd_pkg.sv - shared command-word layout, opcodes and arbiter FSM states
package periph_cmd_pkg;

   localparam int CMD_W = 24;
   localparam int OP_HI = 23;
   localparam int OP_LO = 16;

   localparam logic [7:0] OP_RUN  = 8'd1;
   localparam logic [7:0] OP_STOP = 8'd2;
   localparam logic [7:0] OP_SET  = 8'd3;
   localparam logic [7:0] OP_GET  = 8'd4;
   localparam logic [7:0] OP_ON   = 8'd5;
   localparam logic [7:0] OP_OFF  = 8'd6;

   localparam logic [CMD_W-1:0] ERR_RSP = 24'hFF0000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - rotating-priority search: first set req bit at or after ptr, wrapping
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx
);

   int               j;
   logic [IDX_W-1:0] jj;

   // Scan from farthest to nearest so the candidate closest to ptr wins last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      j         = 0;
      jj        = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         jj = IDX_W'(j);
         if (req[jj]) begin
            gnt_valid = 1'b1;
            gnt_idx   = jj;
         end
      end
   end

endmodule

// File: rtl/periph_cmd_arbiter.sv
// rtl/periph_cmd_arbiter.sv - round-robin sharing of one command/response peripheral port
// Optional WAIT timeout enabled by defining ARB_TIMEOUT_EN.
module periph_cmd_arbiter
   import periph_cmd_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*CMD_W-1:0] req_cmd,
   output logic [N_REQ-1:0]       req_ack,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [CMD_W-1:0]       rsp_data,
   output logic                   p_start,
   output logic [CMD_W-1:0]       p_in,
   input  logic                   p_rdy,
   input  logic [CMD_W-1:0]       p_out,
   output logic                   busy,
   output logic                   err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] g;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;
   logic [CMD_W-1:0] cmds [N_REQ];
   logic             pick_get;
   logic             cur_get;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) cmds[i] = req_cmd[i*CMD_W +: CMD_W];
   end

   assign pick_get = (cmds[pick_idx][OP_HI:OP_LO] == OP_GET);
   assign cur_get  = (p_in[OP_HI:OP_LO] == OP_GET);

   rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .req       (req),
      .ptr       (ptr),
      .gnt_valid (pick_valid),
      .gnt_idx   (pick_idx)
   );

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

`ifdef ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] wcnt;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign err = 1'b0;
`endif

   // Outputs are registered, so each state's pulses are scheduled one edge early.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         g         <= '0;
         req_ack   <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         p_start   <= 1'b0;
         p_in      <= '0;
         busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         wcnt      <= '0;
         err       <= 1'b0;
`endif
      end else begin
         p_start   <= 1'b0;
         req_ack   <= '0;
         rsp_valid <= '0;
`ifdef ARB_TIMEOUT_EN
         err       <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  g       <= pick_idx;
                  p_in    <= cmds[pick_idx];
                  ptr     <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                  p_start <= 1'b1;
                  busy    <= 1'b1;
                  state   <= S_ISSUE;
                  if (!pick_get) req_ack <= onehot(pick_idx);
               end
            end
            S_ISSUE: begin
               if (!cur_get) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (p_rdy) begin
                  rsp_data  <= p_out;
                  rsp_valid <= onehot(g);
                  req_ack   <= onehot(g);
                  state     <= S_DONE;
               end else begin
`ifdef ARB_TIMEOUT_EN
                  wcnt  <= '0;
`endif
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (p_rdy) begin
                  rsp_data  <= p_out;
                  rsp_valid <= onehot(g);
                  req_ack   <= onehot(g);
                  state     <= S_DONE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (wcnt == TO_W'(TIMEOUT - 1)) begin
                  rsp_data  <= ERR_RSP;
                  err       <= 1'b1;
                  rsp_valid <= onehot(g);
                  req_ack   <= onehot(g);
                  state     <= S_DONE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
`endif
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_periph_cmd_arbiter.sv
// tb/tb_periph_cmd_arbiter.sv - scoreboard bench for periph_cmd_arbiter (timeout case under ARB_TIMEOUT_EN)
module tb_periph_cmd_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [95:0] req_cmd;
   logic [3:0]  req_ack;
   logic [3:0]  rsp_valid;
   logic [23:0] rsp_data;
   logic        p_start;
   logic [23:0] p_in;
   logic        p_rdy;
   logic [23:0] p_out;
   logic        busy;
   logic        err;

   periph_cmd_arbiter #(.N_REQ(4), .TIMEOUT(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_cmd   (req_cmd),
      .req_ack   (req_ack),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .p_start   (p_start),
      .p_in      (p_in),
      .p_rdy     (p_rdy),
      .p_out     (p_out),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          cyc;
      logic [23:0] cmd;
   } iss_t;

   typedef struct {
      int          cyc;
      logic [3:0]  ack;
      logic [3:0]  vld;
      logic [23:0] data;
      logic        err;
   } ack_t;

   iss_t iss_q[$];
   ack_t ack_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_iss(input int c, input logic [23:0] cmd);
      iss_t e;
      e.cyc = c;
      e.cmd = cmd;
      iss_q.push_back(e);
   endtask

   task automatic push_ack(input int c, input logic [3:0] a, input logic [3:0] v,
                           input logic [23:0] d, input logic e_err);
      ack_t e;
      e.cyc  = c;
      e.ack  = a;
      e.vld  = v;
      e.data = d;
      e.err  = e_err;
      ack_q.push_back(e);
   endtask

   task automatic set_cmd(input int i, input logic [23:0] cmd);
      req_cmd[24*i +: 24] = cmd;
   endtask

   task automatic wait_ack(input int i, input int max);
      bit got = 1'b0;
      for (int n = 0; n < max; n++) begin
         @(negedge clk);
         if (req_ack[i]) begin
            got = 1'b1;
            break;
         end
      end
      chk($sformatf("ack%0d_seen", i), 32'(got), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_p_start"}, 32'(p_start), 32'd0);
      chk({tag, "_p_in"}, 32'(p_in), 32'd0);
      chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
      chk({tag, "_req_ack"}, 32'(req_ack), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   // Monitor: every DUT issue or completion pops the next expectation.
   always @(negedge clk) begin
      if (rst) begin
         if (p_start) begin
            chk("issue_expected", 32'(iss_q.size() != 0), 32'd1);
            if (iss_q.size() != 0) begin
               iss_t e;
               e = iss_q.pop_front();
               chk("issue_cycle", 32'(cyc), 32'(e.cyc));
               chk("p_in", 32'(p_in), 32'(e.cmd));
            end
         end
         if (req_ack != 4'd0 || rsp_valid != 4'd0) begin
            chk("ack_expected", 32'(ack_q.size() != 0), 32'd1);
            if (ack_q.size() != 0) begin
               ack_t e;
               e = ack_q.pop_front();
               chk("ack_cycle", 32'(cyc), 32'(e.cyc));
               chk("req_ack", 32'(req_ack), 32'(e.ack));
               chk("rsp_valid", 32'(rsp_valid), 32'(e.vld));
               if (e.vld != 4'd0) chk("rsp_data", 32'(rsp_data), 32'(e.data));
               chk("err", 32'(err), 32'(e.err));
            end
         end else begin
            chk("err_idle", 32'(err), 32'd0);
         end
      end
   end

   int t0;
   int t1;
   logic [23:0] rr_cmd [4];

   initial begin
      rst     = 1'b0;
      req     = 4'd0;
      req_cmd = '0;
      p_rdy   = 1'b0;
      p_out   = 24'd0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b1;

      // Round-robin with all four requests held, all non-GET.
      rr_cmd[0] = 24'h010000;
      rr_cmd[1] = 24'h020001;
      rr_cmd[2] = 24'h030002;
      rr_cmd[3] = 24'h050003;
      @(negedge clk);
      t0 = cyc;
      for (int i = 0; i < 4; i++) set_cmd(i, rr_cmd[i]);
      req = 4'hF;
      for (int k = 0; k < 5; k++) begin
         push_iss(t0 + 1 + 2*k, rr_cmd[k % 4]);
         push_ack(t0 + 1 + 2*k, 4'(1 << (k % 4)), 4'd0, 24'd0, 1'b0);
      end
      for (int k = 0; k < 5; k++) wait_ack(k % 4, 6);
      req = 4'd0;

      // Single non-GET from requester 1.
      @(negedge clk);
      t0 = cyc;
      set_cmd(1, 24'h010000);
      req = 4'b0010;
      push_iss(t0 + 1, 24'h010000);
      push_ack(t0 + 1, 4'b0010, 4'd0, 24'd0, 1'b0);
      wait_ack(1, 4);
      req = 4'd0;

      // GET answered in the issue cycle.
      @(negedge clk);
      t0 = cyc;
      set_cmd(0, 24'h040000);
      req = 4'b0001;
      push_iss(t0 + 1, 24'h040000);
      push_ack(t0 + 2, 4'b0001, 4'b0001, 24'h041234, 1'b0);
      @(negedge clk);
      p_rdy = 1'b1;
      p_out = 24'h041234;
      wait_ack(0, 4);
      p_rdy = 1'b0;
      req   = 4'd0;

      // Stray strobe while idle.
      @(negedge clk);
      p_rdy = 1'b1;
      p_out = 24'hDEAD00;
      @(negedge clk);
      p_rdy = 1'b0;
      @(negedge clk);
      chk("stray_rsp_data", 32'(rsp_data), 32'h041234);
      chk("stray_busy", 32'(busy), 32'd0);

      // GET from requester 2 answered 5 cycles after issue.
      t0 = cyc;
      set_cmd(2, 24'h040000);
      req = 4'b0100;
      push_iss(t0 + 1, 24'h040000);
      push_ack(t0 + 7, 4'b0100, 4'b0100, 24'h04ABCD, 1'b0);
      chk("busy_c0", 32'(busy), 32'd0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk($sformatf("busy_c%0d", k), 32'(busy), 32'd1);
         if (k == 6) begin
            p_rdy = 1'b1;
            p_out = 24'h04ABCD;
         end
         if (k == 7) begin
            p_rdy = 1'b0;
            req   = 4'd0;
         end
      end
      @(negedge clk);
      chk("busy_c8", 32'(busy), 32'd0);

`ifdef ARB_TIMEOUT_EN
      // Hung GET: error response after TIMEOUT wait cycles, then normal service.
      @(negedge clk);
      t0 = cyc;
      set_cmd(0, 24'h040000);
      req = 4'b0001;
      push_iss(t0 + 1, 24'h040000);
      push_ack(t0 + 17, 4'b0001, 4'b0001, 24'hFF0000, 1'b1);
      wait_ack(0, 25);
      req = 4'd0;
      @(negedge clk);
      t1 = cyc;
      set_cmd(2, 24'h060002);
      req = 4'b0100;
      push_iss(t1 + 1, 24'h060002);
      push_ack(t1 + 1, 4'b0100, 4'd0, 24'd0, 1'b0);
      wait_ack(2, 4);
      req = 4'd0;
`endif

      // Reset in the middle of WAIT abandons the command; ptr restarts at 0.
      @(negedge clk);
      t0 = cyc;
      set_cmd(1, 24'h040000);
      req = 4'b0010;
      push_iss(t0 + 1, 24'h040000);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_all_zero("midwait_reset");
      req = 4'd0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      t1 = cyc;
      set_cmd(1, 24'h010011);
      set_cmd(3, 24'h020033);
      req = 4'b1010;
      push_iss(t1 + 1, 24'h010011);
      push_ack(t1 + 1, 4'b0010, 4'd0, 24'd0, 1'b0);
      push_iss(t1 + 3, 24'h020033);
      push_ack(t1 + 3, 4'b1000, 4'd0, 24'd0, 1'b0);
      wait_ack(1, 4);
      req = 4'b1000;
      wait_ack(3, 4);
      req = 4'd0;

      repeat (4) @(negedge clk);
      chk("issue_queue_drained", 32'(iss_q.size()), 32'd0);
      chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/periph_cmd_arbiter.md
# periph_cmd_arbiter

Shares one 24-bit command/response peripheral port (`{opcode[23:16], payload[15:0]}` with a single-cycle start strobe and an `rdy` response strobe, as used by the RTC peripheral) between N requesters. It grants round-robin, issues each command as a one-cycle start pulse, and for response-bearing opcodes (GET) waits for the peripheral's `rdy`. It then routes the captured response back to the granted requester. It sits between the CPU/DMA command sources and the peripheral.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `TIMEOUT`, 15, max WAIT cycles before an error response (used only when `ARB_TIMEOUT_EN` is defined).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request; held high with `req_cmd` until that requester's `req_ack`.
- `req_cmd`  in  N_REQ*24  packed commands; requester i uses bits `[24*i+23:24*i]`.
- `req_ack`  out  N_REQ  one-cycle completion pulse, one-hot.
- `rsp_valid`  out  N_REQ  one-cycle response pulse, one-hot; coincides with `req_ack` for GET.
- `rsp_data`  out  24  response word; valid while any `rsp_valid` bit is high.
- `p_start`  out  1  one-cycle command strobe to the peripheral.
- `p_in`  out  24  command word to the peripheral; held stable from issue until the next grant.
- `p_rdy`  in  1  peripheral response strobe.
- `p_out`  in  24  peripheral response word; sampled when `p_rdy` is high.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  one-cycle timeout pulse (always 0 without `ARB_TIMEOUT_EN`).

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- **IDLE:** if `req` is nonzero, pick the first set bit at or after `ptr`, wrapping. Latch grant index `g` and `req_cmd[g]` into `p_in`, set `ptr = (g+1) mod N_REQ`, then go to ISSUE. If `req` is zero, stay in IDLE.
- **ISSUE:** `p_start=1`.
  - Opcode != OP_GET: `req_ack[g]=1` this cycle, then go to IDLE.
  - Opcode == OP_GET and `p_rdy=1`: capture `p_out` into `rsp_data`, go to DONE.
  - Opcode == OP_GET and `p_rdy=0`: go to WAIT.
- **WAIT:** `p_start=0`.
  - `p_rdy=1`: capture `p_out`, go to DONE.
  - `ARB_TIMEOUT_EN` defined and wait counter == TIMEOUT-1: `rsp_data = ERR_RSP` (24'hFF0000), pulse `err`, go to DONE.
- **DONE:** `rsp_valid[g]=1`, `req_ack[g]=1`, go to IDLE.
- `p_rdy` is ignored in IDLE, in DONE, and in ISSUE for non-GET opcodes. Stray strobes have no effect.
- Requests that arrive while busy are held by their requesters and arbitrated at the next IDLE. `req` deasserting while not granted is legal.
- A requester that drops `req` after being granted is still serviced; its ack is delivered regardless.
- `rsp_data` holds its last value between responses.
- Reset (any state, any time): state IDLE, `ptr=0`, wait counter 0, and all outputs 0 including `p_in` and `rsp_data`. An in-flight command is abandoned with no ack.

## Timing
- Cycle 0: IDLE samples `req`.
- Cycle 1: `p_start`/`p_in` valid (ISSUE).
  - Non-GET: `req_ack` in cycle 1.
  - GET with same-cycle `p_rdy`: `rsp_valid`/`req_ack` in cycle 2.
  - GET with `p_rdy` k cycles after the issue cycle: response in cycle 2+k.
- Minimum spacing between consecutive grants: 2 cycles for non-GET, 3 cycles for immediate GET.
- Timeout: with no `p_rdy`, WAIT lasts TIMEOUT cycles; `err` and the error response appear in the following DONE cycle.
- Requesters drop or replace `req` on the edge after sampling `req_ack`, so IDLE never re-grants a completed request.

## Configuration
- `ARB_TIMEOUT_EN` defined: WAIT has a counter of width `$clog2(TIMEOUT+1)`. Timeout behaviour is as above.
- `ARB_TIMEOUT_EN` undefined: no counter. WAIT exits only on `p_rdy` (a hung peripheral blocks the arbiter), and `err` is tied to 0.

## Structure
- Shared package `periph_cmd_pkg` holds:
  - opcode constants: RUN=1, STOP=2, SET=3, GET=4, ON=5, OFF=6;
  - `CMD_W=24` and opcode field bounds `[23:16]`;
  - `ERR_RSP`;
  - the FSM state enum.
- Sub-module `rr_picker` (combinational): inputs `req` and `ptr`; outputs `gnt_valid` and a binary grant index. The rotating-priority search is isolated here for separate testing.

## Test plan
- Single non-GET: req[1], `req_cmd` = 24'h010000 (RUN). Expect `p_start` with `p_in` = 24'h010000 in cycle 1, `req_ack` = 4'b0010 in cycle 1, and `rsp_valid` = 0.
- GET with immediate `p_rdy`: req[0], cmd 24'h040000, peripheral returns 24'h041234 in the issue cycle. Expect `rsp_valid[0]` in cycle 2 with `rsp_data` = 24'h041234.
- Round-robin: `req` = 4'b1111 held, all non-GET. Grants go 0,1,2,3,0 with a grant every 2 cycles; `ptr` wraps from 3 to 0.
- Delayed GET plus a stray strobe: `p_rdy` pulses while IDLE (no effect). GET from req[2] is answered 5 cycles after issue with 24'h04ABCD. Expect `rsp_valid[2]` in cycle 7 and `busy` high in cycles 1–7.
- Timeout (`ARB_TIMEOUT_EN`, TIMEOUT=15): GET issued with no `p_rdy`. Expect `err`, `rsp_data` = 24'hFF0000, and `rsp_valid[g]` in cycle 17. The next request is granted normally.
- Reset mid-WAIT: `rst` low during WAIT. Expect all outputs 0 immediately, `ptr` = 0, and after release the lowest set `req` bit is granted first.
